oport_arb: RTL and testbench
============================

Name: oport_arb

Overview:
- One output-port arbiter per router direction.
- Collects the per-input arb_req bit for its direction from the five input buffers (N,S,E,W,B) and issues a one-hot round-robin grant.
- Muxes the winning payload into a one-cycle registered output stage that feeds the output buffer.
- Five instances per router, one per output direction; each instance masks U-turn requests.

Parameters:
- PYLD_W, `PKT_W, payload width in bits.
- OUT_DIR, `DIR_N, direction this instance drives; requests from input OUT_DIR are ignored unless OUT_DIR == `DIR_B.
- CNT_W, 16, width of the saturating transfer counter.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous active-high reset.
- req_i  input  5  bit i = arb_req[OUT_DIR] of input buffer i.
- payload_i  input  5*PYLD_W  slice i = payload_o of input buffer i.
- obuf_rdy_i  input  1  output buffer can accept a flit this cycle.
- en_mask_i  input  5  per-input enable; 0 blocks that input (static configuration, may change any cycle).
- gnt_o  output  5  one-hot grant; combinational from current state and inputs.
- obuf_vld_o  output  1  registered valid to the output buffer.
- payload_o  output  PYLD_W  registered payload to the output buffer.
- xfer_cnt_o  output  CNT_W  saturating count of accepted transfers.

Behaviour:
- Reset: synchronous on posedge clk when rst=1. Clears rr_ptr=0, obuf_vld_o=0, payload_o=0, xfer_cnt_o=0. gnt_o is 0 while rst=1.
- Effective request: eff = req_i & en_mask_i & ~uturn.
  - uturn = one-hot(OUT_DIR) when OUT_DIR != `DIR_B, else 0.
- Grant: round-robin search of eff starting at index rr_ptr, ascending, wrapping 4->0.
  - gnt_o is one-hot on the first set bit found; all-zero if eff == 0.
  - gnt_o is asserted regardless of obuf_rdy_i; the input buffer clears its request only on gnt & obuf_rdy.
- Transfer: xfer = |gnt_o & obuf_rdy_i.
- On xfer (registered, latency 1):
  - payload_o <= payload_i slice of the granted index.
  - obuf_vld_o <= 1.
  - rr_ptr <= (granted index + 1) mod 5.
  - xfer_cnt_o increments and saturates at all-ones.
- No xfer: obuf_vld_o <= 0; payload_o, rr_ptr and xfer_cnt_o hold.
- Grant without obuf_rdy_i: gnt_o stays on the same index next cycle (rr_ptr unchanged), so the holder is not preempted by lower-priority new arrivals.
- Back-to-back: a requester is never granted twice in a row while another eff bit is set. Worst-case wait for any enabled requester is 4 transfers.
- rr_ptr only ever holds values 0..4; any other value is unreachable.
- Mask change mid-grant: the new mask applies combinationally the same cycle; a dropped request simply loses the grant.
- Reset mid-transfer: a transfer in the cycle where rst=1 is discarded, and gnt_o=0 guarantees no input buffer clears its request.

Decomposition:
- Direction indices `DIR_N=0, `DIR_S=1, `DIR_E=2, `DIR_W=3, `DIR_B=4 and `PKT_W live in the shared param.v; no new constants.
- One natural sub-module: rr_pick5. Combinational function with inputs eff[4:0] and ptr[2:0], outputs one-hot gnt[4:0] and idx[2:0]. Reusable by the other arbiters.

Test Plan:
- Reset, OUT_DIR=`DIR_E, req_i=5'b11111, en_mask_i=5'b11111, obuf_rdy_i=1 -> gnt_o sequence N,S,W,B,N,... (E never granted); obuf_vld_o=1 from cycle 2; xfer_cnt_o=4 after 4 grants.
- req_i=5'b00011 (N,S), obuf_rdy_i=0 for 3 cycles then 1 -> gnt_o=N held 3 cycles, one transfer of N's payload, next grant S; obuf_vld_o high exactly 1 cycle per transfer.
- S granted (rr_ptr=2) then req_i adds W and B -> grant order W, B, N, S; no requester starves across 20 cycles of full load.
- en_mask_i=5'b10111 with all requests -> W never granted; deasserting mask bit mid-grant drops gnt_o to next requester the same cycle.
- CNT_W=4, continuous transfers for 20 cycles -> xfer_cnt_o saturates at 15 and stays there.
- rst=1 asserted during a granted cycle with obuf_rdy_i=1 -> gnt_o=0 that cycle; next cycle obuf_vld_o=0, payload_o=0, xfer_cnt_o=0, first grant after release goes to the lowest requesting index from N.

Source files
------------

// File: rtl/oport_arb_pkg.sv
// oport_arb_pkg: shared router direction indices, flit width and U-turn mask helper.
package oport_arb_pkg;
  localparam int DIR_N = 0;
  localparam int DIR_S = 1;
  localparam int DIR_E = 2;
  localparam int DIR_W = 3;
  localparam int DIR_B = 4;
  localparam int PKT_W = 16;
  function automatic logic [4:0] uturn_mask(input int dir);
    return (dir == DIR_B) ? 5'b0 : 5'b1 << dir;
  endfunction
endpackage

// File: rtl/rr_pick5.sv
// rr_pick5: one-hot round-robin pick over five requests, starting the search at ptr.
module rr_pick5 (
  input  logic [4:0] eff,
  input  logic [2:0] ptr,
  output logic [4:0] gnt,
  output logic [2:0] idx
);
  logic [2:0] j;
  always_comb begin
    gnt = '0;
    idx = '0;
    j = '0;
    for (int k = 4; k >= 0; k--) begin
      j = 3'((int'(ptr) + k) % 5);
      if (eff[j]) begin
        gnt = 5'b1 << j;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/oport_arb.sv
// oport_arb: per-direction output-port round-robin arbiter with registered payload stage.
module oport_arb
  import oport_arb_pkg::*;
#(
  parameter int PYLD_W  = PKT_W,
  parameter int OUT_DIR = DIR_N,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          req_i,
  input  logic [5*PYLD_W-1:0] payload_i,
  input  logic                obuf_rdy_i,
  input  logic [4:0]          en_mask_i,
  output logic [4:0]          gnt_o,
  output logic                obuf_vld_o,
  output logic [PYLD_W-1:0]   payload_o,
  output logic [CNT_W-1:0]    xfer_cnt_o
);
  logic [4:0] eff;
  logic [2:0] idx, rr_ptr;
  logic       xfer;
  // Forcing eff low during reset keeps gnt_o at zero, so no buffer pops a flit that gets discarded.
  assign eff  = rst ? '0 : req_i & en_mask_i & ~uturn_mask(OUT_DIR);
  assign xfer = |gnt_o & obuf_rdy_i;
  rr_pick5 u_pick (.eff(eff), .ptr(rr_ptr), .gnt(gnt_o), .idx(idx));
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      obuf_vld_o <= 1'b0;
      payload_o  <= '0;
      xfer_cnt_o <= '0;
    end else begin
      obuf_vld_o <= xfer;
      if (xfer) begin
        payload_o  <= payload_i[idx*PYLD_W +: PYLD_W];
        rr_ptr     <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        xfer_cnt_o <= xfer_cnt_o + CNT_W'(~&xfer_cnt_o);
      end
    end
  end
endmodule

// File: tb/tb_oport_arb.sv
// tb_oport_arb: directed checks of grant order, stalls, masking, saturation and reset.
module tb_oport_arb;
  import oport_arb_pkg::*;
  localparam int W = PKT_W;
  logic clk = 0, rst = 1, rdy = 0;
  logic [4:0] req = '0, en = 5'b11111;
  logic [5*W-1:0] pay_in;
  logic [4:0] gnt, gnt_b;
  logic vld, vld_b;
  logic [W-1:0] pay, pay_b;
  logic [3:0] cnt, cnt_b;
  int total = 0, bad = 0;
  int gcnt [5];
  int w_hits;
  logic [4:0] g, prev;

  always #5 clk = ~clk;

  oport_arb #(.PYLD_W(W), .OUT_DIR(DIR_E), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req_i(req), .payload_i(pay_in), .obuf_rdy_i(rdy),
    .en_mask_i(en), .gnt_o(gnt), .obuf_vld_o(vld), .payload_o(pay), .xfer_cnt_o(cnt));
  oport_arb #(.PYLD_W(W), .OUT_DIR(DIR_B), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .req_i(req), .payload_i(pay_in), .obuf_rdy_i(rdy),
    .en_mask_i(en), .gnt_o(gnt_b), .obuf_vld_o(vld_b), .payload_o(pay_b), .xfer_cnt_o(cnt_b));

  function automatic logic [W-1:0] pv(input int k);
    return W'(16'hA5A0 + k);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 5; k++) pay_in[k*W +: W] = pv(k);
    // reset with everything requesting: no grant while rst is high
    req = 5'b11111; rdy = 1;
    #1 chk("rst_gnt", gnt, 0);
    chk("rst_gnt_b", gnt_b, 0);
    tick();
    chk("rst_vld", vld, 0);
    chk("rst_pay", pay, 0);
    chk("rst_cnt", cnt, 0);
    rst = 0;
    #1 chk("rr_n", gnt, 5'b00001);
    tick();
    chk("rr_vld1", vld, 1);
    chk("rr_pay_n", pay, pv(0));
    chk("rr_s", gnt, 5'b00010);
    tick();
    chk("rr_w_skip_e", gnt, 5'b01000);
    tick();
    chk("rr_b", gnt, 5'b10000);
    tick();
    chk("rr_n_wrap", gnt, 5'b00001);
    chk("rr_cnt4", cnt, 4);
    // stall: N holds grant while output buffer is not ready
    req = 5'b00011; rdy = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_gnt", gnt, 5'b00001);
      tick();
      chk("stall_vld", vld, 0);
    end
    chk("stall_cnt", cnt, 4);
    rdy = 1;
    #1 chk("stall_rel_gnt", gnt, 5'b00001);
    tick();
    chk("stall_xfer_vld", vld, 1);
    chk("stall_xfer_pay", pay, pv(0));
    chk("stall_next_s", gnt, 5'b00010);
    rdy = 0;
    tick();
    chk("vld_one_cycle", vld, 0);
    chk("s_held", gnt, 5'b00010);
    // S transfers, then W and B arrive: order W, B, N, S
    rdy = 1;
    tick();
    chk("s_pay", pay, pv(1));
    req = 5'b11011;
    #1 chk("ord_w", gnt, 5'b01000);
    tick();
    chk("ord_b", gnt, 5'b10000);
    chk("ord_w_pay", pay, pv(3));
    tick();
    chk("ord_n", gnt, 5'b00001);
    tick();
    chk("ord_s", gnt, 5'b00010);
    tick();
    chk("cnt10", cnt, 10);
    // full load: fair shares, no back-to-back repeat, counter saturates
    prev = '0;
    for (int k = 0; k < 5; k++) gcnt[k] = 0;
    for (int i = 0; i < 20; i++) begin
      g = gnt;
      chk("no_b2b", g != prev, 1);
      for (int k = 0; k < 5; k++) if (g[k]) gcnt[k]++;
      prev = g;
      tick();
    end
    chk("share_n", gcnt[0], 5);
    chk("share_s", gcnt[1], 5);
    chk("share_e", gcnt[2], 0);
    chk("share_w", gcnt[3], 5);
    chk("share_b", gcnt[4], 5);
    chk("cnt_sat", cnt, 15);
    tick();
    chk("cnt_sat_hold", cnt, 15);
    // masking W, then dropping B's enable mid-grant
    req = 5'b11111; en = 5'b10111;
    #1 chk("mask_b", gnt, 5'b10000);
    en = 5'b00111;
    #1 chk("mask_drop_n", gnt, 5'b00001);
    en = 5'b10111;
    w_hits = 0;
    for (int i = 0; i < 8; i++) begin
      if (gnt[3]) w_hits++;
      tick();
    end
    chk("mask_w_never", w_hits, 0);
    // reset during a granted, ready cycle
    en = 5'b11111; req = 5'b11100; rst = 1;
    #1 chk("rst_mid_gnt", gnt, 0);
    chk("rst_mid_gnt_b", gnt_b, 0);
    tick();
    chk("rst_mid_vld", vld, 0);
    chk("rst_mid_pay", pay, 0);
    chk("rst_mid_cnt", cnt, 0);
    rst = 0;
    #1 chk("rel_first_w", gnt, 5'b01000);
    chk("rel_first_b_e", gnt_b, 5'b00100);
    tick();
    chk("rel_pay", pay, pv(3));
    chk("rel_cnt", cnt, 1);
    // B-direction instance keeps B requests; E instance drops E requests
    req = 5'b00100;
    #1 chk("uturn_e", gnt, 0);
    chk("b_keeps_e", gnt_b, 5'b00100);
    tick();
    chk("uturn_e_vld", vld, 0);
    chk("b_vld", vld_b, 1);
    chk("b_pay", pay_b, pv(2));
    chk("b_cnt", cnt_b, 2);
    req = 5'b10000;
    #1 chk("e_takes_b", gnt, 5'b10000);
    chk("b_takes_b", gnt_b, 5'b10000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
